// File: rtl/sipo_operand_loader.sv
// sipo_operand_loader
//
// Deserialises one frame of NUM_OPS operands, WIDTH bits each, from a single
// serial line and hands the completed set to the multiplier core over a
// valid/ready handshake. Operand 0 is multiplicand A, operand 1 is multiplier B.
// The serial side stalls (in_ready=0) while a completed frame is waiting.
//
// Optional feature macro: SIPO_PARITY_EN
//   When defined, each frame carries one trailing even-parity bit after the
//   last data bit. That bit is counted in bit_count but not stored in ops.
//   parity_err is latched when the frame completes and is held through FULL.
//   When the macro is not defined, parity_err is tied to 0.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   serial_in   in   serial data bit
//   in_valid    in   serial_in carries a valid bit this cycle
//   in_ready    out  loader accepts a bit this cycle (state LOAD)
//   abort       in   synchronous frame discard, highest priority
//   ops         out  operand i on ops[i*WIDTH +: WIDTH]
//   out_valid   out  ops holds a complete frame (state FULL)
//   out_ready   in   consumer accepts the frame
//   bit_count   out  accepted bits in the current frame
//   parity_err  out  frame parity check result (1 = error)
//
// State | meaning
// ------+-----------------------------------------------------------
// LOAD  | accepting serial bits into ops, in_ready=1
// FULL  | frame complete, out_valid=1, serial input ignored

module sipo_operand_loader #(
    parameter  int WIDTH      = 4,
    parameter  int NUM_OPS    = 2,
    parameter  int MSB_FIRST  = 1,
    localparam int DATA_BITS  = NUM_OPS * WIDTH,
`ifdef SIPO_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 1,
`else
    localparam int FRAME_BITS = DATA_BITS,
`endif
    localparam int CW         = $clog2(FRAME_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serial_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 abort,
    output logic [DATA_BITS-1:0] ops,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        bit_count,
    output logic                 parity_err
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 accept;
    logic                 last_bit;
    logic                 handshake;
    logic [DATA_BITS-1:0] ops_d;

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_FULL);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign last_bit  = (bit_count == CW'(FRAME_BITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: if (accept && last_bit) state_d = ST_FULL;
                ST_FULL: if (out_ready)          state_d = ST_LOAD;
                default:                         state_d = ST_LOAD;
            endcase
        end
    end

    // Only the operand addressed by the current bit position shifts. The
    // parity bit position (bit_count == DATA_BITS) matches no operand, so it
    // never lands in ops.
    always_comb begin
        ops_d = ops;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (bit_count >= CW'(i * WIDTH) && bit_count < CW'((i + 1) * WIDTH)) begin
                if (MSB_FIRST != 0) begin
                    ops_d[i*WIDTH +: WIDTH] = {ops[i*WIDTH +: WIDTH-1], serial_in};
                end else begin
                    ops_d[i*WIDTH +: WIDTH] = {serial_in, ops[i*WIDTH+1 +: WIDTH-1]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ops       <= '0;
            bit_count <= '0;
        end else if (abort) begin
            ops       <= '0;
            bit_count <= '0;
        end else if (handshake) begin
            // ops is held after the handshake; it is overwritten bit by bit.
            bit_count <= '0;
        end else if (accept) begin
            ops       <= ops_d;
            bit_count <= bit_count + CW'(1);
        end
    end

`ifdef SIPO_PARITY_EN
    logic par_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_acc    <= 1'b0;
            parity_err <= 1'b0;
        end else if (abort || handshake) begin
            par_acc    <= 1'b0;
            parity_err <= 1'b0;
        end else if (accept) begin
            par_acc <= par_acc ^ serial_in;
            if (last_bit) begin
                parity_err <= par_acc ^ serial_in;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_operand_loader.sv
module tb_sipo_operand_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    // shared stimulus for the two 4x2 instances
    logic       s_in = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_abort = 1'b0;
    logic       s_oready = 1'b0;

    logic       a_in_ready, a_out_valid, a_parity_err;
    logic [7:0] a_ops;
    logic [3:0] a_bit_count;
    logic       b_in_ready, b_out_valid, b_parity_err;
    logic [7:0] b_ops;
    logic [3:0] b_bit_count;

    // stimulus for the 8x3 instance
    logic        c_in = 1'b0;
    logic        c_valid = 1'b0;
    logic        c_abort = 1'b0;
    logic        c_oready = 1'b0;
    logic        c_in_ready, c_out_valid, c_parity_err;
    logic [23:0] c_ops;
    logic [4:0]  c_bit_count;

    int checks = 0;
    int passed = 0;

    sipo_operand_loader #(.WIDTH(4), .NUM_OPS(2), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .serial_in(s_in), .in_valid(s_valid),
        .in_ready(a_in_ready), .abort(s_abort), .ops(a_ops), .out_valid(a_out_valid),
        .out_ready(s_oready), .bit_count(a_bit_count), .parity_err(a_parity_err)
    );

    sipo_operand_loader #(.WIDTH(4), .NUM_OPS(2), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .serial_in(s_in), .in_valid(s_valid),
        .in_ready(b_in_ready), .abort(s_abort), .ops(b_ops), .out_valid(b_out_valid),
        .out_ready(s_oready), .bit_count(b_bit_count), .parity_err(b_parity_err)
    );

    sipo_operand_loader #(.WIDTH(8), .NUM_OPS(3), .MSB_FIRST(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .serial_in(c_in), .in_valid(c_valid),
        .in_ready(c_in_ready), .abort(c_abort), .ops(c_ops), .out_valid(c_out_valid),
        .out_ready(c_oready), .bit_count(c_bit_count), .parity_err(c_parity_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s_in = b;
        s_valid = 1'b1;
        step();
    endtask

    task automatic send_c(input logic b);
        c_in = b;
        c_valid = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_in_ready); else passed++;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", a_out_valid); else passed++;
        checks++; if (a_ops !== 8'h00) $display("FAIL reset_ops: got %h want 00", a_ops); else passed++;
        checks++; if (a_bit_count !== 4'd0) $display("FAIL reset_bit_count: got %0d want 0", a_bit_count); else passed++;
        checks++; if (a_parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", a_parity_err); else passed++;
        checks++; if (c_ops !== 24'h0) $display("FAIL reset_c_ops: got %h want 000000", c_ops); else passed++;
        #2 reset_n = 1'b1;
        step();
    endtask

    task automatic test_continuous_frame();
        logic [7:0] stream;
        stream = 8'b1011_0110;   // sent left to right: 1,0,1,1,0,1,1,0
        for (int i = 7; i >= 1; i--) send_bit(stream[i]);
        checks++; if (a_bit_count !== 4'd7) $display("FAIL cont_count7: got %0d want 7", a_bit_count); else passed++;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL cont_early_valid: got %b want 0", a_out_valid); else passed++;
        send_bit(stream[0]);
        checks++; if (a_out_valid !== 1'b1) $display("FAIL cont_out_valid: got %b want 1", a_out_valid); else passed++;
        checks++; if (a_in_ready !== 1'b0) $display("FAIL cont_in_ready: got %b want 0", a_in_ready); else passed++;
        checks++; if (a_ops !== 8'h6B) $display("FAIL cont_msb_ops: got %h want 6B", a_ops); else passed++;
        checks++; if (a_bit_count !== 4'd8) $display("FAIL cont_count8: got %0d want 8", a_bit_count); else passed++;
        checks++; if (b_ops !== 8'h6D) $display("FAIL cont_lsb_ops: got %h want 6D", b_ops); else passed++;
        checks++; if (b_out_valid !== 1'b1) $display("FAIL cont_lsb_valid: got %b want 1", b_out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        s_oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_bit(i[0]);
            checks++;
            if (a_in_ready !== 1'b0 || a_ops !== 8'h6B || a_bit_count !== 4'd8 || a_out_valid !== 1'b1)
                $display("FAIL bp_hold[%0d]: got rdy=%b ops=%h cnt=%0d vld=%b want rdy=0 ops=6B cnt=8 vld=1",
                         i, a_in_ready, a_ops, a_bit_count, a_out_valid);
            else passed++;
        end
        s_oready = 1'b1;
        send_bit(1'b1);          // presented during handshake: must be ignored
        s_oready = 1'b0;
        s_valid = 1'b0;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", a_in_ready); else passed++;
        checks++; if (a_bit_count !== 4'd0) $display("FAIL bp_release_count: got %0d want 0", a_bit_count); else passed++;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", a_out_valid); else passed++;
        checks++; if (a_ops !== 8'h6B) $display("FAIL bp_ops_held: got %h want 6B", a_ops); else passed++;
    endtask

    task automatic test_gapped();
        logic [7:0] stream;
        stream = 8'b1011_0110;
        s_oready = 1'b1;         // no effect while loading
        for (int i = 7; i >= 0; i--) begin
            send_bit(stream[i]);
            s_in = ~stream[i];
            s_valid = 1'b0;
            step();
            if (i != 0) begin
                checks++;
                if (a_bit_count !== 4'(8 - i))
                    $display("FAIL gap_count: got %0d want %0d", a_bit_count, 8 - i);
                else passed++;
            end
            if (i == 1) s_oready = 1'b0;
        end
        checks++; if (a_ops !== 8'h6B) $display("FAIL gap_msb_ops: got %h want 6B", a_ops); else passed++;
        checks++; if (b_ops !== 8'h6D) $display("FAIL gap_lsb_ops: got %h want 6D", b_ops); else passed++;
        checks++; if (a_bit_count !== 4'd8) $display("FAIL gap_count8: got %0d want 8", a_bit_count); else passed++;
        s_oready = 1'b1;
        step();
        s_oready = 1'b0;
    endtask

    task automatic test_abort_full();
        logic [7:0] stream;
        stream = 8'b1111_0000;
        for (int i = 7; i >= 0; i--) send_bit(stream[i]);
        s_valid = 1'b0;
        checks++; if (a_ops !== 8'h0F || a_out_valid !== 1'b1) $display("FAIL abf_frame: got ops=%h vld=%b want 0F/1", a_ops, a_out_valid); else passed++;
        s_abort = 1'b1;
        step();
        s_abort = 1'b0;
        checks++;
        if (a_ops !== 8'h00 || a_bit_count !== 4'd0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
            $display("FAIL abf_clear: got ops=%h cnt=%0d rdy=%b vld=%b want 00/0/1/0",
                     a_ops, a_bit_count, a_in_ready, a_out_valid);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [7:0] stream;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        s_valid = 1'b0;
        checks++; if (a_bit_count !== 4'd3) $display("FAIL ar_pre_count: got %0d want 3", a_bit_count); else passed++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (a_ops !== 8'h00 || a_bit_count !== 4'd0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
            $display("FAIL ar_immediate: got ops=%h cnt=%0d rdy=%b vld=%b want 00/0/1/0",
                     a_ops, a_bit_count, a_in_ready, a_out_valid);
        else passed++;
        #1 reset_n = 1'b1;
        stream = 8'b0011_1100;
        for (int i = 7; i >= 0; i--) send_bit(stream[i]);
        s_valid = 1'b0;
        checks++; if (a_ops !== 8'hC3) $display("FAIL ar_msb_ops: got %h want C3", a_ops); else passed++;
        checks++; if (b_ops !== 8'h3C) $display("FAIL ar_lsb_ops: got %h want 3C", b_ops); else passed++;
        checks++; if (a_out_valid !== 1'b1) $display("FAIL ar_valid: got %b want 1", a_out_valid); else passed++;
        s_oready = 1'b1;
        step();
        s_oready = 1'b0;
    endtask

    task automatic send_c_data(input logic [23:0] data, input int nbits);
        for (int k = 0; k < nbits; k++) send_c(data[(k / 8) * 8 + 7 - (k % 8)]);
    endtask

    task automatic test_wide_frame();
        send_c_data(24'hFF3CA5, 24);
`ifdef SIPO_PARITY_EN
        checks++; if (c_out_valid !== 1'b0) $display("FAIL wide_wait_parity: got %b want 0", c_out_valid); else passed++;
        send_c(1'b0);
        c_valid = 1'b0;
        checks++; if (c_bit_count !== 5'd25) $display("FAIL wide_count: got %0d want 25", c_bit_count); else passed++;
`else
        c_valid = 1'b0;
        checks++; if (c_bit_count !== 5'd24) $display("FAIL wide_count: got %0d want 24", c_bit_count); else passed++;
`endif
        checks++; if (c_ops !== 24'hFF3CA5) $display("FAIL wide_ops: got %h want FF3CA5", c_ops); else passed++;
        checks++; if (c_out_valid !== 1'b1) $display("FAIL wide_valid: got %b want 1", c_out_valid); else passed++;
        checks++; if (c_parity_err !== 1'b0) $display("FAIL wide_parity_ok: got %b want 0", c_parity_err); else passed++;
        c_oready = 1'b1;
        step();
        c_oready = 1'b0;
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity_err();
        send_c_data(24'hFF3CA5, 24);
        send_c(1'b1);
        c_valid = 1'b0;
        checks++; if (c_parity_err !== 1'b1) $display("FAIL par_err: got %b want 1", c_parity_err); else passed++;
        checks++; if (c_out_valid !== 1'b1 || c_ops !== 24'hFF3CA5) $display("FAIL par_delivered: got vld=%b ops=%h want 1/FF3CA5", c_out_valid, c_ops); else passed++;
        step();
        checks++; if (c_parity_err !== 1'b1) $display("FAIL par_held: got %b want 1", c_parity_err); else passed++;
        c_oready = 1'b1;
        step();
        c_oready = 1'b0;
        checks++; if (c_parity_err !== 1'b0) $display("FAIL par_cleared: got %b want 0", c_parity_err); else passed++;
    endtask
`endif

    task automatic test_abort_mid();
        send_c_data(24'hFF3CA5, 10);
        checks++; if (c_bit_count !== 5'd10) $display("FAIL abm_count10: got %0d want 10", c_bit_count); else passed++;
        c_abort = 1'b1;
        send_c(1'b1);
        c_abort = 1'b0;
        c_valid = 1'b0;
        checks++; if (c_ops !== 24'h0) $display("FAIL abm_ops: got %h want 000000", c_ops); else passed++;
        checks++; if (c_bit_count !== 5'd0) $display("FAIL abm_count: got %0d want 0", c_bit_count); else passed++;
        checks++; if (c_in_ready !== 1'b1) $display("FAIL abm_ready: got %b want 1", c_in_ready); else passed++;
        send_c(1'b1);
        c_valid = 1'b0;
        checks++; if (c_bit_count !== 5'd1 || c_ops !== 24'h000001) $display("FAIL abm_restart: got cnt=%0d ops=%h want 1/000001", c_bit_count, c_ops); else passed++;
    endtask

    initial begin
        test_reset();
        test_continuous_frame();
        test_backpressure();
        test_gapped();
        test_abort_full();
        test_async_reset();
        test_wide_frame();
`ifdef SIPO_PARITY_EN
        test_parity_err();
`endif
        test_abort_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
